// File: rtl/axi_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : axi_cmd_master
// Description : Turns single commands (write, read, poll-until-match) into
//               AXI4-Lite master transactions and returns one response per
//               command.
//
//   Command side : cmd_valid/cmd_ready handshake. cmd_op selects the
//                  operation: 00 write, 01 read, 10 poll, 11 reserved.
//                  cmd_addr, cmd_wdata, cmd_wstrb, cmd_mask, cmd_match and
//                  cmd_poll_limit are captured on acceptance.
//   Response side: rsp_valid/rsp_ready handshake. rsp_rdata holds the last
//                  read data, rsp_status is 00 ok, 01 AXI error, 10 poll
//                  timeout, 11 bad op. rsp_polls is the number of reads issued.
//   busy         : high whenever the engine is not idle.
//   M_AXI_*      : AXI4-Lite master (AW, W, B, AR, R channels).
//
// Revision    : 1.0 - initial release
// ============================================================================
module axi_cmd_master #(
    parameter int addr_width = 32,
    parameter int data_width = 64,
    parameter int poll_width = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    // command channel
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [1:0]                cmd_op,
    input  logic [addr_width-1:0]     cmd_addr,
    input  logic [data_width-1:0]     cmd_wdata,
    input  logic [data_width/8-1:0]   cmd_wstrb,
    input  logic [data_width-1:0]     cmd_mask,
    input  logic [data_width-1:0]     cmd_match,
    input  logic [poll_width-1:0]     cmd_poll_limit,
    // response channel
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [data_width-1:0]     rsp_rdata,
    output logic [1:0]                rsp_status,
    output logic [poll_width-1:0]     rsp_polls,
    output logic                      busy,
    // AXI4-Lite write address channel
    output logic [addr_width-1:0]     M_AXI_AWADDR,
    output logic [2:0]                M_AXI_AWPROT,
    output logic                      M_AXI_AWVALID,
    input  logic                      M_AXI_AWREADY,
    // AXI4-Lite write data channel
    output logic [data_width-1:0]     M_AXI_WDATA,
    output logic [data_width/8-1:0]   M_AXI_WSTRB,
    output logic                      M_AXI_WVALID,
    input  logic                      M_AXI_WREADY,
    // AXI4-Lite write response channel
    input  logic [1:0]                M_AXI_BRESP,
    input  logic                      M_AXI_BVALID,
    output logic                      M_AXI_BREADY,
    // AXI4-Lite read address channel
    output logic [addr_width-1:0]     M_AXI_ARADDR,
    output logic [2:0]                M_AXI_ARPROT,
    output logic                      M_AXI_ARVALID,
    input  logic                      M_AXI_ARREADY,
    // AXI4-Lite read data channel
    input  logic [data_width-1:0]     M_AXI_RDATA,
    input  logic [1:0]                M_AXI_RRESP,
    input  logic                      M_AXI_RVALID,
    output logic                      M_AXI_RREADY
);

    localparam logic [1:0] c_OP_WRITE   = 2'b00;
    localparam logic [1:0] c_OP_READ    = 2'b01;
    localparam logic [1:0] c_OP_POLL    = 2'b10;
    localparam logic [1:0] c_OP_BAD     = 2'b11;

    localparam logic [1:0] c_ST_OK      = 2'b00;
    localparam logic [1:0] c_ST_AXI_ERR = 2'b01;
    localparam logic [1:0] c_ST_TIMEOUT = 2'b10;
    localparam logic [1:0] c_ST_BAD_OP  = 2'b11;

    localparam logic [1:0] c_RESP_OKAY  = 2'b00;

    localparam logic [poll_width-1:0] c_POLL_ONE = poll_width'(1);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        WR_ADDR_DATA = 3'd1,
        WR_RESP      = 3'd2,
        RD_ADDR      = 3'd3,
        RD_DATA      = 3'd4,
        RESP         = 3'd5
    } state_t;

    state_t                    r_state;
    state_t                    w_next_state;

    logic [1:0]                r_op;
    logic [addr_width-1:0]     r_addr;
    logic [data_width-1:0]     r_wdata;
    logic [data_width/8-1:0]   r_wstrb;
    logic [data_width-1:0]     r_mask;
    logic [data_width-1:0]     r_match;
    logic [poll_width-1:0]     r_limit;
    logic [poll_width-1:0]     r_polls;
    logic [data_width-1:0]     r_rdata;
    logic [1:0]                r_status;
    logic                      r_aw_done;
    logic                      r_w_done;

    logic                      w_cmd_fire;
    logic                      w_aw_fire;
    logic                      w_w_fire;
    logic                      w_ar_fire;
    logic                      w_r_fire;
    logic                      w_b_fire;
    logic                      w_poll_hit;
    logic                      w_poll_last;

    // ------------------------------------------------------------------
    // Outputs are decoded from the state and registered flags only, so no
    // VALID ever depends combinationally on a READY.
    // ------------------------------------------------------------------
    assign cmd_ready     = (r_state == IDLE) && !reset;
    assign busy          = (r_state != IDLE);
    assign rsp_valid     = (r_state == RESP);
    assign rsp_rdata     = r_rdata;
    assign rsp_status    = r_status;
    assign rsp_polls     = r_polls;

    assign M_AXI_AWADDR  = r_addr;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = (r_state == WR_ADDR_DATA) && !r_aw_done;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = r_wstrb;
    assign M_AXI_WVALID  = (r_state == WR_ADDR_DATA) && !r_w_done;
    assign M_AXI_BREADY  = (r_state == WR_RESP);
    assign M_AXI_ARADDR  = r_addr;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = (r_state == RD_ADDR);
    assign M_AXI_RREADY  = (r_state == RD_DATA);

    assign w_cmd_fire  = cmd_valid && cmd_ready;
    assign w_aw_fire   = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_w_fire    = M_AXI_WVALID && M_AXI_WREADY;
    assign w_b_fire    = M_AXI_BVALID && M_AXI_BREADY;
    assign w_ar_fire   = M_AXI_ARVALID && M_AXI_ARREADY;
    assign w_r_fire    = M_AXI_RVALID && M_AXI_RREADY;

    // Only the masked bits take part in the poll comparison.
    assign w_poll_hit  = ((M_AXI_RDATA ^ r_match) & r_mask) == '0;
    // r_polls already counts the read whose data is now arriving.
    assign w_poll_last = (r_polls == r_limit);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_cmd_fire) begin
                    case (cmd_op)
                        c_OP_WRITE: w_next_state = WR_ADDR_DATA;
                        c_OP_READ,
                        c_OP_POLL:  w_next_state = RD_ADDR;
                        default:    w_next_state = RESP;
                    endcase
                end
            end
            WR_ADDR_DATA: begin
                // Each channel may complete in an earlier cycle or in this one.
                if ((r_aw_done || w_aw_fire) && (r_w_done || w_w_fire)) begin
                    w_next_state = WR_RESP;
                end
            end
            WR_RESP: begin
                if (w_b_fire) begin
                    w_next_state = RESP;
                end
            end
            RD_ADDR: begin
                if (w_ar_fire) begin
                    w_next_state = RD_DATA;
                end
            end
            RD_DATA: begin
                if (w_r_fire) begin
                    if ((M_AXI_RRESP != c_RESP_OKAY) || (r_op != c_OP_POLL) ||
                        w_poll_hit || w_poll_last) begin
                        w_next_state = RESP;
                    end else begin
                        w_next_state = RD_ADDR;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Command capture, handshake bookkeeping and response fields
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op      <= c_OP_WRITE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_mask    <= '0;
            r_match   <= '0;
            r_limit   <= '0;
            r_polls   <= '0;
            r_rdata   <= '0;
            r_status  <= c_ST_OK;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_cmd_fire) begin
                        r_op      <= cmd_op;
                        r_addr    <= cmd_addr;
                        r_wdata   <= cmd_wdata;
                        r_wstrb   <= cmd_wstrb;
                        r_mask    <= cmd_mask;
                        r_match   <= cmd_match;
                        // A limit of zero still allows one read.
                        r_limit   <= (cmd_poll_limit == '0) ? c_POLL_ONE : cmd_poll_limit;
                        r_polls   <= '0;
                        r_rdata   <= '0;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_status  <= (cmd_op == c_OP_BAD) ? c_ST_BAD_OP : c_ST_OK;
                    end
                end
                WR_ADDR_DATA: begin
                    if (w_aw_fire) begin
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_fire) begin
                        r_w_done <= 1'b1;
                    end
                end
                WR_RESP: begin
                    if (w_b_fire) begin
                        r_status <= (M_AXI_BRESP == c_RESP_OKAY) ? c_ST_OK : c_ST_AXI_ERR;
                    end
                end
                RD_ADDR: begin
                    // Saturating read counter.
                    if (w_ar_fire && (r_polls != '1)) begin
                        r_polls <= r_polls + c_POLL_ONE;
                    end
                end
                RD_DATA: begin
                    if (w_r_fire) begin
                        r_rdata <= M_AXI_RDATA;
                        if (M_AXI_RRESP != c_RESP_OKAY) begin
                            r_status <= c_ST_AXI_ERR;
                        end else if ((r_op == c_OP_POLL) && !w_poll_hit && w_poll_last) begin
                            r_status <= c_ST_TIMEOUT;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_cmd_master
// Description : Directed self-checking bench for axi_cmd_master with a small
//               behavioural AXI4-Lite slave (programmable read data, read and
//               write response codes, and READY levels).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_cmd_master;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_addr;
    logic [63:0] cmd_wdata;
    logic [7:0]  cmd_wstrb;
    logic [63:0] cmd_mask;
    logic [63:0] cmd_match;
    logic [15:0] cmd_poll_limit;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic [1:0]  rsp_status;
    logic [15:0] rsp_polls;
    logic        busy;

    logic [31:0] M_AXI_AWADDR;
    logic [2:0]  M_AXI_AWPROT;
    logic        M_AXI_AWVALID;
    logic        M_AXI_AWREADY;
    logic [63:0] M_AXI_WDATA;
    logic [7:0]  M_AXI_WSTRB;
    logic        M_AXI_WVALID;
    logic        M_AXI_WREADY;
    logic [1:0]  M_AXI_BRESP;
    logic        M_AXI_BVALID;
    logic        M_AXI_BREADY;
    logic [31:0] M_AXI_ARADDR;
    logic [2:0]  M_AXI_ARPROT;
    logic        M_AXI_ARVALID;
    logic        M_AXI_ARREADY;
    logic [63:0] M_AXI_RDATA;
    logic [1:0]  M_AXI_RRESP;
    logic        M_AXI_RVALID;
    logic        M_AXI_RREADY;

    int n_cmp;
    int n_err;

    axi_cmd_master #(
        .addr_width (32),
        .data_width (64),
        .poll_width (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_addr       (cmd_addr),
        .cmd_wdata      (cmd_wdata),
        .cmd_wstrb      (cmd_wstrb),
        .cmd_mask       (cmd_mask),
        .cmd_match      (cmd_match),
        .cmd_poll_limit (cmd_poll_limit),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_rdata      (rsp_rdata),
        .rsp_status     (rsp_status),
        .rsp_polls      (rsp_polls),
        .busy           (busy),
        .M_AXI_AWADDR   (M_AXI_AWADDR),
        .M_AXI_AWPROT   (M_AXI_AWPROT),
        .M_AXI_AWVALID  (M_AXI_AWVALID),
        .M_AXI_AWREADY  (M_AXI_AWREADY),
        .M_AXI_WDATA    (M_AXI_WDATA),
        .M_AXI_WSTRB    (M_AXI_WSTRB),
        .M_AXI_WVALID   (M_AXI_WVALID),
        .M_AXI_WREADY   (M_AXI_WREADY),
        .M_AXI_BRESP    (M_AXI_BRESP),
        .M_AXI_BVALID   (M_AXI_BVALID),
        .M_AXI_BREADY   (M_AXI_BREADY),
        .M_AXI_ARADDR   (M_AXI_ARADDR),
        .M_AXI_ARPROT   (M_AXI_ARPROT),
        .M_AXI_ARVALID  (M_AXI_ARVALID),
        .M_AXI_ARREADY  (M_AXI_ARREADY),
        .M_AXI_RDATA    (M_AXI_RDATA),
        .M_AXI_RRESP    (M_AXI_RRESP),
        .M_AXI_RVALID   (M_AXI_RVALID),
        .M_AXI_RREADY   (M_AXI_RREADY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural AXI4-Lite slave
    // ------------------------------------------------------------------
    logic        slv_clr;
    logic [63:0] rd_vals [8];
    logic [1:0]  rd_resp;
    logic [1:0]  wr_resp;
    logic [2:0]  rd_idx;
    logic        aw_got;
    logic        w_got;
    int          aw_cnt;
    int          w_cnt;
    int          b_cnt;
    int          ar_cnt;

    wire aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
    wire w_hs  = M_AXI_WVALID && M_AXI_WREADY;

    always @(posedge clk) begin
        if (reset || slv_clr) begin
            aw_got       <= 1'b0;
            w_got        <= 1'b0;
            M_AXI_BVALID <= 1'b0;
            M_AXI_BRESP  <= 2'b00;
            M_AXI_RVALID <= 1'b0;
            M_AXI_RDATA  <= '0;
            M_AXI_RRESP  <= 2'b00;
            rd_idx       <= '0;
            aw_cnt       <= 0;
            w_cnt        <= 0;
            b_cnt        <= 0;
            ar_cnt       <= 0;
        end else begin
            if (aw_hs) aw_cnt <= aw_cnt + 1;
            if (w_hs)  w_cnt  <= w_cnt + 1;
            if (M_AXI_BVALID) begin
                if (M_AXI_BREADY) begin
                    M_AXI_BVALID <= 1'b0;
                    b_cnt        <= b_cnt + 1;
                end
            end else if ((aw_got || aw_hs) && (w_got || w_hs)) begin
                M_AXI_BVALID <= 1'b1;
                M_AXI_BRESP  <= wr_resp;
                aw_got       <= 1'b0;
                w_got        <= 1'b0;
            end else begin
                if (aw_hs) aw_got <= 1'b1;
                if (w_hs)  w_got  <= 1'b1;
            end
            if (M_AXI_RVALID && M_AXI_RREADY) begin
                M_AXI_RVALID <= 1'b0;
            end
            if (M_AXI_ARVALID && M_AXI_ARREADY) begin
                M_AXI_RVALID <= 1'b1;
                M_AXI_RDATA  <= rd_vals[rd_idx];
                M_AXI_RRESP  <= rd_resp;
                rd_idx       <= (rd_idx == 3'd7) ? rd_idx : rd_idx + 3'd1;
                ar_cnt       <= ar_cnt + 1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_slave();
        slv_clr = 1'b1;
        tick();
        slv_clr = 1'b0;
    endtask

    // Returns positioned in cycle 1 (the cycle after the accepting edge).
    task automatic send_cmd(input logic [1:0] op, input logic [31:0] addr,
                            input logic [63:0] wdata, input logic [7:0] wstrb,
                            input logic [63:0] mask, input logic [63:0] match,
                            input logic [15:0] limit);
        int n;
        cmd_op         = op;
        cmd_addr       = addr;
        cmd_wdata      = wdata;
        cmd_wstrb      = wstrb;
        cmd_mask       = mask;
        cmd_match      = match;
        cmd_poll_limit = limit;
        cmd_valid      = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        if (!cmd_ready) check_val("cmd_accept_timeout", 64'd0, 64'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int start, output int cyc);
        cyc = start;
        while (!rsp_valid && cyc < 200) begin
            tick();
            cyc++;
        end
        if (!rsp_valid) check_val("rsp_timeout", 64'd0, 64'd1);
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------
    initial begin
        int cyc;
        n_cmp          = 0;
        n_err          = 0;
        reset          = 1'b1;
        slv_clr        = 1'b0;
        cmd_valid      = 1'b0;
        cmd_op         = 2'b00;
        cmd_addr       = '0;
        cmd_wdata      = '0;
        cmd_wstrb      = '0;
        cmd_mask       = '0;
        cmd_match      = '0;
        cmd_poll_limit = '0;
        rsp_ready      = 1'b0;
        M_AXI_AWREADY  = 1'b1;
        M_AXI_WREADY   = 1'b1;
        M_AXI_ARREADY  = 1'b1;
        rd_resp        = 2'b00;
        wr_resp        = 2'b00;
        for (int i = 0; i < 8; i++) rd_vals[i] = '0;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_cmd_ready", cmd_ready, 0);
        check_val("rst_rsp_valid", rsp_valid, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_awvalid", M_AXI_AWVALID, 0);
        check_val("rst_wvalid", M_AXI_WVALID, 0);
        check_val("rst_bready", M_AXI_BREADY, 0);
        check_val("rst_arvalid", M_AXI_ARVALID, 0);
        check_val("rst_rready", M_AXI_RREADY, 0);
        check_val("rst_awaddr", M_AXI_AWADDR, 0);
        check_val("rst_araddr", M_AXI_ARADDR, 0);
        check_val("rst_wdata", M_AXI_WDATA, 0);
        check_val("rst_wstrb", M_AXI_WSTRB, 0);
        check_val("rst_rdata", rsp_rdata, 0);
        check_val("rst_status", rsp_status, 0);
        check_val("rst_polls", rsp_polls, 0);
        reset = 1'b0;
        #1;
        check_val("post_rst_cmd_ready", cmd_ready, 1);

        // ---- basic write, zero-wait slave ----
        clr_slave();
        send_cmd(2'b00, 32'h10, 64'h1122334455667788, 8'hFF, 64'h0, 64'h0, 16'd0);
        check_val("wr_c1_awvalid", M_AXI_AWVALID, 1);
        check_val("wr_c1_wvalid", M_AXI_WVALID, 1);
        check_val("wr_c1_awaddr", M_AXI_AWADDR, 64'h10);
        check_val("wr_c1_wdata", M_AXI_WDATA, 64'h1122334455667788);
        check_val("wr_c1_wstrb", M_AXI_WSTRB, 8'hFF);
        check_val("wr_c1_busy", busy, 1);
        check_val("wr_c1_cmd_ready", cmd_ready, 0);
        tick();
        check_val("wr_c2_bready", M_AXI_BREADY, 1);
        check_val("wr_c2_awvalid", M_AXI_AWVALID, 0);
        check_val("wr_c2_wvalid", M_AXI_WVALID, 0);
        wait_rsp(2, cyc);
        check_val("wr_latency", cyc, 3);
        check_val("wr_status", rsp_status, 2'b00);
        check_val("wr_polls", rsp_polls, 0);
        check_val("wr_b_count", b_cnt, 1);
        finish_rsp();
        check_val("wr_rsp_drop", rsp_valid, 0);
        check_val("wr_idle_ready", cmd_ready, 1);

        // ---- split write handshake: WREADY three cycles after AWREADY ----
        clr_slave();
        M_AXI_WREADY = 1'b0;
        send_cmd(2'b00, 32'h20, 64'hA5A5_0000_FFFF_5A5A, 8'h0F, 64'h0, 64'h0, 16'd0);
        check_val("split_c1_awvalid", M_AXI_AWVALID, 1);
        check_val("split_c1_wvalid", M_AXI_WVALID, 1);
        tick();
        check_val("split_c2_awvalid", M_AXI_AWVALID, 0);
        check_val("split_c2_wvalid", M_AXI_WVALID, 1);
        tick();
        check_val("split_c3_wvalid", M_AXI_WVALID, 1);
        check_val("split_c3_wdata", M_AXI_WDATA, 64'hA5A5_0000_FFFF_5A5A);
        tick();
        check_val("split_c4_wvalid", M_AXI_WVALID, 1);
        M_AXI_WREADY = 1'b1;
        tick();
        check_val("split_c5_wvalid", M_AXI_WVALID, 0);
        check_val("split_c5_bready", M_AXI_BREADY, 1);
        wait_rsp(5, cyc);
        check_val("split_latency", cyc, 6);
        check_val("split_status", rsp_status, 2'b00);
        check_val("split_aw_count", aw_cnt, 1);
        check_val("split_w_count", w_cnt, 1);
        finish_rsp();
        repeat (3) tick();
        check_val("split_b_count", b_cnt, 1);

        // ---- write with SLVERR response ----
        clr_slave();
        wr_resp = 2'b10;
        send_cmd(2'b00, 32'h30, 64'h1, 8'h01, 64'h0, 64'h0, 16'd0);
        wait_rsp(1, cyc);
        check_val("wrerr_status", rsp_status, 2'b01);
        finish_rsp();
        wr_resp = 2'b00;

        // ---- poll until match: data 1,1,0 with mask 1, match 0 ----
        clr_slave();
        rd_vals[0] = 64'h1;
        rd_vals[1] = 64'h1;
        rd_vals[2] = 64'h0;
        send_cmd(2'b10, 32'h40, 64'h0, 8'h00, 64'h1, 64'h0, 16'd10);
        check_val("pm_c1_arvalid", M_AXI_ARVALID, 1);
        check_val("pm_c1_araddr", M_AXI_ARADDR, 64'h40);
        wait_rsp(1, cyc);
        check_val("pm_latency", cyc, 7);
        check_val("pm_status", rsp_status, 2'b00);
        check_val("pm_polls", rsp_polls, 3);
        check_val("pm_rdata", rsp_rdata, 0);
        check_val("pm_ar_count", ar_cnt, 3);
        finish_rsp();

        // ---- poll timeout: limit 4, never matches ----
        clr_slave();
        for (int i = 0; i < 8; i++) rd_vals[i] = 64'h3;
        send_cmd(2'b10, 32'h44, 64'h0, 8'h00, 64'h1, 64'h0, 16'd4);
        wait_rsp(1, cyc);
        check_val("pt_latency", cyc, 9);
        check_val("pt_status", rsp_status, 2'b10);
        check_val("pt_polls", rsp_polls, 4);
        check_val("pt_rdata", rsp_rdata, 64'h3);
        check_val("pt_ar_count", ar_cnt, 4);
        finish_rsp();

        // ---- poll limit 0 behaves as 1 ----
        clr_slave();
        send_cmd(2'b10, 32'h48, 64'h0, 8'h00, 64'h1, 64'h0, 16'd0);
        wait_rsp(1, cyc);
        check_val("pz_status", rsp_status, 2'b10);
        check_val("pz_polls", rsp_polls, 1);
        check_val("pz_ar_count", ar_cnt, 1);
        finish_rsp();

        // ---- poll match ignores bits outside the mask ----
        clr_slave();
        rd_vals[0] = 64'hFF00;
        send_cmd(2'b10, 32'h4C, 64'h0, 8'h00, 64'hFF, 64'h1200, 16'd5);
        wait_rsp(1, cyc);
        check_val("pmask_status", rsp_status, 2'b00);
        check_val("pmask_polls", rsp_polls, 1);
        finish_rsp();

        // ---- read with SLVERR and response backpressure ----
        clr_slave();
        rd_vals[0] = 64'hDEAD_BEEF_0000_1234;
        rd_resp    = 2'b10;
        send_cmd(2'b01, 32'h80, 64'h0, 8'h00, 64'h0, 64'h0, 16'd0);
        wait_rsp(1, cyc);
        check_val("rderr_latency", cyc, 3);
        check_val("rderr_status", rsp_status, 2'b01);
        check_val("rderr_rdata", rsp_rdata, 64'hDEAD_BEEF_0000_1234);
        check_val("rderr_polls", rsp_polls, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("hold_rsp_valid", rsp_valid, 1);
            check_val("hold_status", rsp_status, 2'b01);
            check_val("hold_rdata", rsp_rdata, 64'hDEAD_BEEF_0000_1234);
            check_val("hold_polls", rsp_polls, 1);
            check_val("hold_cmd_ready", cmd_ready, 0);
        end
        // Offer a command in the release cycle; it must not be taken then.
        cmd_op    = 2'b11;
        cmd_valid = 1'b1;
        finish_rsp();
        cmd_valid = 1'b0;
        check_val("release_rsp_valid", rsp_valid, 0);
        check_val("release_cmd_ready", cmd_ready, 1);
        rd_resp = 2'b00;

        // ---- reset during RD_DATA abandons the read ----
        clr_slave();
        send_cmd(2'b01, 32'h100, 64'h0, 8'h00, 64'h0, 64'h0, 16'd0);
        check_val("rst_mid_c1_arvalid", M_AXI_ARVALID, 1);
        tick();
        check_val("rst_mid_c2_rready", M_AXI_RREADY, 1);
        reset = 1'b1;
        tick();
        check_val("rst_mid_arvalid", M_AXI_ARVALID, 0);
        check_val("rst_mid_rready", M_AXI_RREADY, 0);
        check_val("rst_mid_busy", busy, 0);
        reset = 1'b0;
        repeat (3) tick();
        check_val("rst_mid_no_rsp", rsp_valid, 0);
        check_val("rst_mid_cmd_ready", cmd_ready, 1);

        // ---- reserved op: immediate bad-op response, no AXI traffic ----
        clr_slave();
        send_cmd(2'b11, 32'h200, 64'h55, 8'hFF, 64'h0, 64'h0, 16'd3);
        check_val("bad_rsp_valid", rsp_valid, 1);
        check_val("bad_status", rsp_status, 2'b11);
        check_val("bad_polls", rsp_polls, 0);
        check_val("bad_awvalid", M_AXI_AWVALID, 0);
        check_val("bad_arvalid", M_AXI_ARVALID, 0);
        tick();
        check_val("bad_hold_valid", rsp_valid, 1);
        finish_rsp();
        check_val("bad_aw_count", aw_cnt, 0);
        check_val("bad_w_count", w_cnt, 0);
        check_val("bad_ar_count", ar_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
